// File: rtl/sobel_processing_unit_uc_pkg.sv
// Shared state encodings and sizing helpers for the Sobel processing unit control path.
package sobel_pkg;

  localparam int unsigned ESTADO_W = 4;

  localparam logic [ESTADO_W-1:0] E_INICIAL       = 4'h0;
  localparam logic [ESTADO_W-1:0] E_RECEBE        = 4'h1;
  localparam logic [ESTADO_W-1:0] E_GRAVA         = 4'h2;
  localparam logic [ESTADO_W-1:0] E_CALCULA       = 4'h3;
  localparam logic [ESTADO_W-1:0] E_ESPERA_TX     = 4'h4;
  localparam logic [ESTADO_W-1:0] E_TRANSMITE     = 4'h5;
  localparam logic [ESTADO_W-1:0] E_ESPERA_FIM_TX = 4'h6;
  localparam logic [ESTADO_W-1:0] E_AVANCA        = 4'h7;
  localparam logic [ESTADO_W-1:0] E_ATUALIZA      = 4'h8;
  localparam logic [ESTADO_W-1:0] E_FIM           = 4'h9;
  localparam logic [ESTADO_W-1:0] E_ERRO          = 4'hF;

  typedef enum logic [ESTADO_W-1:0] {
    S_INICIAL       = E_INICIAL,
    S_RECEBE        = E_RECEBE,
    S_GRAVA         = E_GRAVA,
    S_CALCULA       = E_CALCULA,
    S_ESPERA_TX     = E_ESPERA_TX,
    S_TRANSMITE     = E_TRANSMITE,
    S_ESPERA_FIM_TX = E_ESPERA_FIM_TX,
    S_AVANCA        = E_AVANCA,
    S_ATUALIZA      = E_ATUALIZA,
    S_FIM           = E_FIM,
    S_ERRO          = E_ERRO
  } estado_t;

  function automatic int unsigned total_pixels(input int unsigned h, input int unsigned w);
    return h * w;
  endfunction

  // Counter width able to hold 0..m-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sobel_processing_unit_uc_if.sv
// Handshake bundle between the control unit and the UART/FD side of the Sobel datapath.
interface sobel_processing_unit_uc_if;
  import sobel_pkg::*;

  logic                iniciar;
  logic                rx_valido;
  logic                fim_imagem;
  logic                tx_livre;
  logic                tx_fim;
  logic                rx_pronto;
  logic                calcula;
  logic                tx_pronto;
  logic                tx_partida;
  logic                ocupado;
  logic                pronto;
  logic                erro;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    input  iniciar, rx_valido, fim_imagem, tx_livre, tx_fim,
    output rx_pronto, calcula, tx_pronto, tx_partida, ocupado, pronto, erro, db_estado
  );

  modport slave (
    output iniciar, rx_valido, fim_imagem, tx_livre, tx_fim,
    input  rx_pronto, calcula, tx_pronto, tx_partida, ocupado, pronto, erro, db_estado
  );

endinterface

// File: rtl/sobel_processing_unit_uc_contador.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count M-1.
module contador_m
  import sobel_pkg::*;
#(
  parameter int unsigned M = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     zera,
  input  logic                     conta,
  output logic [cnt_width(M)-1:0]  q,
  output logic                     fim
);

  localparam int unsigned W = cnt_width(M);

  assign fim = (q == W'(M - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= fim ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/sobel_processing_unit_uc.sv
// Frame sequencer for the Sobel FD: receive all pixels, run the compute pass under a
// watchdog, then stream every result byte out through the UART transmitter.
module sobel_processing_unit_uc
  import sobel_pkg::*;
#(
  parameter int unsigned HEIGHT         = 4,
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned TIMEOUT_CICLOS = 1024
) (
  input logic                         clock,
  input logic                         reset,
  sobel_processing_unit_uc_if.master  bus
);

  localparam int unsigned TOTAL = total_pixels(HEIGHT, WIDTH);
  localparam int unsigned PIX_W = cnt_width(TOTAL);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CICLOS);

  estado_t            estado;
  estado_t            proximo;
  logic               zera;
  logic               conta_rx;
  logic               conta_tx;
  logic               conta_to;
  logic               rx_fim;
  logic               tx_fim_cnt;
  logic               to_fim;
  logic [PIX_W-1:0]   cont_rx;
  logic [PIX_W-1:0]   cont_tx;
  logic [TO_W-1:0]    cont_to;
  logic               unused_cont;

  // Counter values are only consumed through their terminal flags.
  assign unused_cont = ^{cont_rx, cont_tx, cont_to};

  assign zera     = ((estado == S_INICIAL) || (estado == S_ERRO)) && bus.iniciar;
  assign conta_rx = (estado == S_GRAVA);
  assign conta_tx = (estado == S_AVANCA);
  assign conta_to = (estado == S_CALCULA);

  contador_m #(.M(TOTAL)) u_cont_rx (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta_rx),
    .q     (cont_rx),
    .fim   (rx_fim)
  );

  contador_m #(.M(TOTAL)) u_cont_tx (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta_tx),
    .q     (cont_tx),
    .fim   (tx_fim_cnt)
  );

  contador_m #(.M(TIMEOUT_CICLOS)) u_cont_to (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta_to),
    .q     (cont_to),
    .fim   (to_fim)
  );

  // Terminal flags are checked before the increment lands, i.e. on the last item.
  always_comb begin
    proximo = estado;
    case (estado)
      S_INICIAL, S_ERRO: if (bus.iniciar)    proximo = S_RECEBE;
      S_RECEBE:          if (bus.rx_valido)  proximo = S_GRAVA;
      S_GRAVA:           proximo = rx_fim ? S_CALCULA : S_RECEBE;
      S_CALCULA: begin
        if (bus.fim_imagem) proximo = S_ESPERA_TX;
        else if (to_fim)    proximo = S_ERRO;
      end
      S_ESPERA_TX:       if (bus.tx_livre)   proximo = S_TRANSMITE;
      S_TRANSMITE:       proximo = S_ESPERA_FIM_TX;
      S_ESPERA_FIM_TX:   if (bus.tx_fim)     proximo = S_AVANCA;
      S_AVANCA:          proximo = tx_fim_cnt ? S_FIM : S_ATUALIZA;
      S_ATUALIZA:        proximo = S_ESPERA_TX;
      S_FIM:             proximo = S_INICIAL;
      default:           proximo = S_INICIAL;
    endcase
  end

  // Moore outputs registered alongside the state, decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= S_INICIAL;
      bus.rx_pronto  <= 1'b0;
      bus.calcula    <= 1'b0;
      bus.tx_pronto  <= 1'b0;
      bus.tx_partida <= 1'b0;
      bus.ocupado    <= 1'b0;
      bus.pronto     <= 1'b0;
      bus.erro       <= 1'b0;
      bus.db_estado  <= E_INICIAL;
    end else begin
      estado         <= proximo;
      bus.rx_pronto  <= (proximo == S_GRAVA);
      bus.calcula    <= (proximo == S_CALCULA);
      bus.tx_pronto  <= (proximo == S_AVANCA);
      bus.tx_partida <= (proximo == S_TRANSMITE);
      bus.ocupado    <= (proximo != S_INICIAL) && (proximo != S_ERRO);
      bus.pronto     <= (proximo == S_FIM);
      bus.erro       <= (proximo == S_ERRO);
      bus.db_estado  <= proximo;
    end
  end

endmodule

// File: tb/tb_sobel_processing_unit_uc.sv
// Scoreboard bench for the Sobel control unit: stimulus queues timed expected pulses,
// a negedge monitor pops and compares them as the DUT raises its outputs.
module tb_sobel_processing_unit_uc;
  import sobel_pkg::*;

  localparam int unsigned H     = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned TO    = 64;
  localparam int          TOTAL = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  sobel_processing_unit_uc_if bus ();

  sobel_processing_unit_uc #(
    .HEIGHT         (H),
    .WIDTH          (W),
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum int {K_RXP, K_CALC_ON, K_CALC_OFF, K_TXS, K_TXP, K_PRONTO, K_ERRO} kind_t;
  typedef struct {
    kind_t kind;
    int    at;
  } req_t;

  req_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rxp = 0, n_txs = 0, n_txp = 0, n_pronto = 0;
  int   calc_run = 0, calc_last = 0;
  logic calc_prev = 1'b0, erro_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input kind_t k, input int at);
    sb.push_back('{kind: k, at: at});
  endtask

  task automatic pop_ev(input kind_t k);
    req_t e;
    if (sb.size() == 0) begin
      chk({"unexpected ", k.name()}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({k.name(), " kind"}, 32'(int'(k)), 32'(int'(e.kind)));
      chk({k.name(), " cycle"}, 32'(cyc), 32'(e.at));
    end
  endtask

  // Monitor: every pulse-cycle of an output must match a queued expectation.
  always @(negedge clock) begin
    if (bus.rx_pronto === 1'b1)  begin n_rxp++;    pop_ev(K_RXP);    end
    if (bus.tx_partida === 1'b1) begin n_txs++;    pop_ev(K_TXS);    end
    if (bus.tx_pronto === 1'b1)  begin n_txp++;    pop_ev(K_TXP);    end
    if (bus.pronto === 1'b1)     begin n_pronto++; pop_ev(K_PRONTO); end
    if (bus.calcula === 1'b1 && calc_prev !== 1'b1) pop_ev(K_CALC_ON);
    if (bus.calcula === 1'b0 && calc_prev === 1'b1) begin
      pop_ev(K_CALC_OFF);
      calc_last = calc_run;
    end
    if (bus.calcula === 1'b1) calc_run = (calc_prev === 1'b1) ? calc_run + 1 : 1;
    if (bus.erro === 1'b1 && erro_prev !== 1'b1) pop_ev(K_ERRO);
    calc_prev = bus.calcula;
    erro_prev = bus.erro;
  end

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic start_frame();
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    chk("start db_estado", 32'(bus.db_estado), 32'h1);
    chk("start ocupado", 32'(bus.ocupado), 32'h1);
    chk("start erro", 32'(bus.erro), 32'h0);
  endtask

  // 16 bytes spaced 4 cycles; dbl holds rx_valido into GRAVA where it must be ignored.
  task automatic recv(input bit dbl, output int c_on);
    c_on = 0;
    for (int i = 0; i < TOTAL; i++) begin
      bus.rx_valido = 1'b1;
      expect_ev(K_RXP, cyc + 1);
      if (i == TOTAL - 1) begin
        c_on = cyc + 2;
        expect_ev(K_CALC_ON, c_on);
      end
      @(negedge clock);
      bus.rx_valido = dbl;
      @(negedge clock);
      bus.rx_valido = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic compute_ok(input int c_on, input int stall, output int p0);
    int n;
    go_to(c_on + 40);
    bus.fim_imagem = 1'b1;
    n = cyc;
    expect_ev(K_CALC_OFF, n + 1);
    if (stall > 0) bus.tx_livre = 1'b0;
    p0 = n + 2 + stall;
    expect_ev(K_TXS, p0);
    @(negedge clock);
    bus.fim_imagem = 1'b0;
    if (stall > 0) begin
      go_to(n + 1 + stall);
      bus.tx_livre = 1'b1;
    end
  endtask

  // abort_after > 0: reset right after that many tx_pronto pulses.
  task automatic transmit(input int p0, input int abort_after);
    int p = p0;
    for (int i = 0; i < TOTAL; i++) begin
      go_to(p + 3);
      bus.tx_fim = 1'b1;
      expect_ev(K_TXP, p + 4);
      if (i == abort_after - 1) begin
        @(negedge clock);
        bus.tx_fim = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("abort db_estado", 32'(bus.db_estado), 32'h0);
        chk("abort ocupado", 32'(bus.ocupado), 32'h0);
        chk("abort scoreboard empty", 32'(sb.size()), 32'd0);
        reset = 1'b0;
        return;
      end
      if (i < TOTAL - 1) expect_ev(K_TXS, p + 7);
      else               expect_ev(K_PRONTO, p + 5);
      @(negedge clock);
      bus.tx_fim = 1'b0;
      if (i == TOTAL - 1) begin
        go_to(p + 7);
        chk("done ocupado", 32'(bus.ocupado), 32'h0);
        chk("done db_estado", 32'(bus.db_estado), 32'h0);
      end
      p += 7;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c_on, p0;
    int b_rxp, b_txs, b_txp, b_pr;
    bus.iniciar    = 1'b0;
    bus.rx_valido  = 1'b0;
    bus.fim_imagem = 1'b0;
    bus.tx_livre   = 1'b1;
    bus.tx_fim     = 1'b0;

    // Reset held three cycles.
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset outputs", 32'({bus.rx_pronto, bus.calcula, bus.tx_pronto, bus.tx_partida,
                              bus.ocupado, bus.pronto, bus.erro}), 32'h0);
    chk("reset db_estado", 32'(bus.db_estado), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    start_frame();

    // Nominal 4x4 frame.
    b_rxp = n_rxp; b_txs = n_txs; b_txp = n_txp; b_pr = n_pronto;
    recv(1'b0, c_on);
    compute_ok(c_on, 0, p0);
    transmit(p0, 0);
    chk("frame rx_pronto count", 32'(n_rxp - b_rxp), 32'd16);
    chk("frame tx_partida count", 32'(n_txs - b_txs), 32'd16);
    chk("frame tx_pronto count", 32'(n_txp - b_txp), 32'd16);
    chk("frame pronto count", 32'(n_pronto - b_pr), 32'd1);
    chk("frame calcula length", 32'(calc_last), 32'd41);

    // Watchdog: fim_imagem never arrives.
    start_frame();
    recv(1'b0, c_on);
    expect_ev(K_CALC_OFF, c_on + TO);
    expect_ev(K_ERRO, c_on + TO);
    go_to(c_on + TO + 2);
    chk("timeout calcula length", 32'(calc_last), 32'(TO));
    chk("timeout erro", 32'(bus.erro), 32'h1);
    chk("timeout db_estado", 32'(bus.db_estado), 32'hF);
    chk("timeout ocupado", 32'(bus.ocupado), 32'h0);
    start_frame();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Stray rx_valido in INICIAL and held into GRAVA.
    bus.rx_valido = 1'b1;
    @(negedge clock);
    bus.rx_valido = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle rx_valido db_estado", 32'(bus.db_estado), 32'h0);
    start_frame();
    b_rxp = n_rxp;
    recv(1'b1, c_on);
    compute_ok(c_on, 0, p0);
    transmit(p0, 0);
    chk("stray rx_pronto count", 32'(n_rxp - b_rxp), 32'd16);

    // Transmitter busy 20 cycles, then reset after the 5th byte, then a clean rerun.
    start_frame();
    recv(1'b0, c_on);
    compute_ok(c_on, 20, p0);
    transmit(p0, 5);
    @(negedge clock);
    start_frame();
    b_txp = n_txp; b_pr = n_pronto;
    recv(1'b0, c_on);
    compute_ok(c_on, 0, p0);
    transmit(p0, 0);
    chk("rerun tx_pronto count", 32'(n_txp - b_txp), 32'd16);
    chk("rerun pronto count", 32'(n_pronto - b_pr), 32'd1);

    repeat (4) @(negedge clock);
    chk("final scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
